// File: rtl/count_monitor_pkg.sv
// rtl/count_monitor_pkg.sv - shared types and helpers for count_monitor
// Purpose: FSM state type, sampled count width and the modulo-8 successor.
// Ports: none (package).
package count_monitor_pkg;

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SYNC   = 2'b01,
    ST_LOCKED = 2'b10
  } state_t;

  // Expected successor of a sampled count; the add wraps 7 -> 0 naturally.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] v);
    return v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/count_monitor.sv
// rtl/count_monitor.sv - sequence checker for the 3-bit free-running counter
// Purpose: samples {c2,c1,c0} on enabled edges, locks after LOCK_N good
//          transitions, then reports wraps and sequence errors.
// Ports:
//   clk, rst_n         clock (rising edge), async active-low reset
//   c0, c1, c2         observed count bits (c0 = LSB)
//   sample_en          sample the count on this edge
//   clr                synchronous clear of wrap_cnt / err_cnt / err_sticky
//   locked             high while in LOCKED
//   err                one-cycle pulse per error detected while LOCKED
//   err_sticky         set by any error, cleared by clr or reset
//   wrap_cnt           7->0 transitions seen while LOCKED (modulo)
//   err_cnt            error count, saturating
//   last_val           most recently sampled count
module count_monitor
  import count_monitor_pkg::*;
#(
  parameter int LOCK_N = 2,
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c0,
  input  logic              c1,
  input  logic              c2,
  input  logic              sample_en,
  input  logic              clr,
  output logic              locked,
  output logic              err,
  output logic              err_sticky,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  last_val
);

  localparam int              RUN_W    = $clog2(LOCK_N + 1);
  localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_N);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [RUN_W-1:0]  r_run;
  logic [RUN_W-1:0]  w_run_nxt;
  logic [CNT_W-1:0]  w_v;
  logic              w_good;
  logic              w_err_det;
  logic              w_wrap_det;

  logic              r_locked;
  logic              r_err;
  logic              r_err_sticky;
  logic [WRAP_W-1:0] r_wrap_cnt;
  logic [ERR_W-1:0]  r_err_cnt;
  logic [CNT_W-1:0]  r_last_val;

  assign w_v    = {c2, c1, c0};
  assign w_good = (w_v == cnt_next(r_last_val));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_run   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= w_run_nxt;
    end
  end

  // Next-state logic; nothing moves without sample_en
  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    if (sample_en) begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_SYNC;
          w_run_nxt   = '0;
        end
        ST_SYNC: begin
          if (w_good) begin
            if (r_run + RUN_W'(1) == RUN_LOCK) begin
              w_state_nxt = ST_LOCKED;
              w_run_nxt   = '0;
            end else begin
              w_run_nxt = r_run + RUN_W'(1);
            end
          end else begin
            w_run_nxt = '0;
          end
        end
        ST_LOCKED: begin
          if (!w_good) begin
            w_state_nxt = ST_SYNC;
            w_run_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_run_nxt   = '0;
        end
      endcase
    end
  end

  // Output decode: events that only count while LOCKED
  always_comb begin
    w_err_det  = 1'b0;
    w_wrap_det = 1'b0;
    if (sample_en && (r_state == ST_LOCKED)) begin
      w_err_det  = !w_good;
      // A good sample after 7 is necessarily 0
      w_wrap_det = w_good && (&r_last_val);
    end
  end

  // Registered status; clr beats a simultaneous error for counters/sticky
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_locked     <= 1'b0;
      r_err        <= 1'b0;
      r_err_sticky <= 1'b0;
      r_wrap_cnt   <= '0;
      r_err_cnt    <= '0;
      r_last_val   <= '0;
    end else begin
      r_locked <= (w_state_nxt == ST_LOCKED);
      r_err    <= w_err_det;
      if (sample_en) begin
        r_last_val <= w_v;
      end
      if (clr) begin
        r_err_sticky <= 1'b0;
        r_wrap_cnt   <= '0;
        r_err_cnt    <= '0;
      end else begin
        if (w_wrap_det) begin
          r_wrap_cnt <= r_wrap_cnt + WRAP_W'(1);
        end
        if (w_err_det) begin
          r_err_sticky <= 1'b1;
          if (r_err_cnt != ERR_MAX) begin
            r_err_cnt <= r_err_cnt + ERR_W'(1);
          end
        end
      end
    end
  end

  assign locked     = r_locked;
  assign err        = r_err;
  assign err_sticky = r_err_sticky;
  assign wrap_cnt   = r_wrap_cnt;
  assign err_cnt    = r_err_cnt;
  assign last_val   = r_last_val;

endmodule
